muldiv_ctrl: RTL
================

# muldiv_ctrl

Controller for the CPU's HI/LO multiply/divide unit. It accepts multiply, divide and HI/LO move operations from the execute stage and latches the operands. It sequences the shared iterative multiplier engine and divider engine through their start/ready handshake. It owns the architectural HI and LO registers and tells the pipeline to stall until a result is committed.

## Interface
Parameters:
- WIDTH, default `CPU_REG_WIDTH` (32): operand width. HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  operation request from execute; sampled only when busy=0.
- op  in  4  operation code; values are defined in the shared package.
- a  in  WIDTH  rs operand; multiplicand or dividend.
- b  in  WIDTH  rt operand; multiplier or divisor.
- flush  in  1  cancel any in-flight operation.
- busy  out  1  unit occupied; the pipeline stalls MFHI/MFLO and new ops while busy=1.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_signd  out  1  signed multiply select.
- mul_a, mul_b  out  WIDTH  held multiplier operands.
- mul_ready  in  1  multiplier idle/result valid.
- mul_product  in  2*WIDTH  multiplier result.
- div_start, div_signd, div_a, div_b: outputs; same meaning for the divider.
- div_ready  in  1  divider idle/result valid.
- div_quot, div_rem  in  WIDTH  divider results.

## Operation
- FSM states: IDLE, ISSUE, WAIT. busy = (state != IDLE).
- IDLE, req=1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch a, b, op, and signedness (set for MULT/DIV).
  - Select the engine: multiplier for MULT/MULTU, divider for DIV/DIVU.
  - Go to ISSUE.
- IDLE, req=1, op = MTHI/MTLO: write a to HI or LO at that edge; stay IDLE; busy stays 0.
- IDLE, req=1, op not defined (or compiled out): ignored; no state change.
- ISSUE: assert the selected engine's start for exactly one cycle, then go to WAIT.
- WAIT: on the first cycle the selected engine's ready=1, commit the result and go to IDLE.
  - Multiply: {HI,LO} ← mul_product.
  - Divide: LO ← div_quot, HI ← div_rem.
- Engine operand and signd outputs are driven from the latched registers and held constant from ISSUE through the commit cycle. Both engines evaluate sign correction combinationally from their live inputs, so the held values must not change.
- When idle, the engine operand outputs keep their last values; start stays 0.
- flush=1 in ISSUE or WAIT: go to IDLE with no HI/LO write. The engine may still be running; the next start restarts it. flush in IDLE has no effect, and a req in the same cycle is dropped.
- rst: state=IDLE, HI=0, LO=0, latched operands=0, both starts=0, busy=0. Reset mid-operation discards the operation.
- req while busy=1: ignored; it is the pipeline's responsibility to hold the request.

## Timing
- Acceptance edge E0; ISSUE is the cycle after E0; WAIT begins the cycle after that.
- Nonzero WIDTH=32 multiply: engine ready returns 33 cycles after ISSUE.
  - busy=1 for 34 cycles.
  - HI/LO are updated at the edge ending the ready cycle and visible on the following cycle, when busy=0.
- Multiply with a zero operand: ready in the first WAIT cycle; busy=1 for 2 cycles.
- Divide latency is set by the divider engine; the controller adds 2 cycles (ISSUE plus the commit cycle).
- WAIT ignores ready in the ISSUE cycle; the engine holds ready low while start=1.

## Configuration
- Macro MULDIV_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU. These sequence the multiplier exactly like MULT/MULTU; at commit, {HI,LO} ← {HI,LO} ± mul_product, 2*WIDTH-bit, wrapping modulo 2^(2*WIDTH).
- Undefined: these op codes are treated as undefined and ignored with busy=0; no accumulator adder is built.

## Structure
- Shared package (cpu_const.vh): op code constants MULDIV_OP_*, FSM state encodings, WIDTH default.
- Sub-module muldiv_acc: the 2*WIDTH add/subtract used for commit. It is instantiated only under MULDIV_MADD_EN. The engines stay external to the controller.

## Test plan
- Reset then MULT a=0xFFFFFFFE (−2), b=3 → busy for 34 cycles, exactly one mul_start pulse with mul_signd=1, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0, b=0x12345678 → busy for 2 cycles, HI=0, LO=0.
- DIVU a=100, b=7 → LO=14, HI=2; div_start pulses once; mul_start stays 0.
- MTHI a=0xDEADBEEF while idle → HI=0xDEADBEEF the next cycle, busy never 1. A req during an in-flight MULT is ignored and HI/LO come from the MULT only.
- MULT in flight with flush on its 10th WAIT cycle → IDLE, HI/LO unchanged. An immediately following MULTU 5×6 gives LO=30, HI=0.
- MULTU 0xFFFFFFFF×2 with MULDIV_MADD_EN defined, then MADDU 1×1 → {HI,LO}=0x00000001_FFFFFFFF. With the macro undefined, the MADDU is ignored and busy stays 0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide controller: op codes,
// FSM state encoding and the default register width.
package muldiv_ctrl_pkg;

   localparam int CPU_REG_WIDTH = 32;

   localparam logic [3:0] MULDIV_OP_NONE  = 4'd0;
   localparam logic [3:0] MULDIV_OP_MULT  = 4'd1;
   localparam logic [3:0] MULDIV_OP_MULTU = 4'd2;
   localparam logic [3:0] MULDIV_OP_DIV   = 4'd3;
   localparam logic [3:0] MULDIV_OP_DIVU  = 4'd4;
   localparam logic [3:0] MULDIV_OP_MTHI  = 4'd5;
   localparam logic [3:0] MULDIV_OP_MTLO  = 4'd6;
   localparam logic [3:0] MULDIV_OP_MADD  = 4'd7;
   localparam logic [3:0] MULDIV_OP_MADDU = 4'd8;
   localparam logic [3:0] MULDIV_OP_MSUB  = 4'd9;
   localparam logic [3:0] MULDIV_OP_MSUBU = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } muldiv_state_t;

   typedef enum logic [1:0] {
      ACC_SET = 2'd0,
      ACC_ADD = 2'd1,
      ACC_SUB = 2'd2
   } acc_mode_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage side of the multiply/divide controller: request, operands,
// flush, stall and the architectural HI/LO values.
interface muldiv_ctrl_if
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = CPU_REG_WIDTH
);
   logic             req;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output req, op, a, b, flush, input busy, hi, lo);
   modport slave  (input req, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/muldiv_acc.sv
// 2*WIDTH-bit accumulate for MADD/MSUB commits; wraps modulo 2^W.
module muldiv_acc #(
   parameter int W = 64
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] addend,
   input  logic         sub,
   output logic [W-1:0] sum
);
   assign sum = sub ? (acc - addend) : (acc + addend);
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: sequences external engines and owns HI/LO.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = CPU_REG_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_ctrl_if.slave       bus,
   output logic               mul_start,
   output logic               mul_signd,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic               mul_ready,
   input  logic [2*WIDTH-1:0] mul_product,
   output logic               div_start,
   output logic               div_signd,
   output logic [WIDTH-1:0]   div_a,
   output logic [WIDTH-1:0]   div_b,
   input  logic               div_ready,
   input  logic [WIDTH-1:0]   div_quot,
   input  logic [WIDTH-1:0]   div_rem
);
   muldiv_state_t      state_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic [WIDTH-1:0]   mul_a_reg, mul_b_reg, div_a_reg, div_b_reg;
   logic               mul_signd_reg, div_signd_reg;
   logic               mul_start_reg, div_start_reg;
   logic               sel_div_reg;
   logic               op_mul, op_div, op_signd;
   logic               engine_ready;
   logic [2*WIDTH-1:0] mul_result;

`ifdef MULDIV_MADD_EN
   acc_mode_t          acc_mode_reg;
   acc_mode_t          op_acc;
   logic [2*WIDTH-1:0] acc_sum;

   muldiv_acc #(.W(2*WIDTH)) u_acc (
      .acc    ({hi_reg, lo_reg}),
      .addend (mul_product),
      .sub    (acc_mode_reg == ACC_SUB),
      .sum    (acc_sum)
   );
   assign mul_result = (acc_mode_reg == ACC_SET) ? mul_product : acc_sum;
`else
   assign mul_result = mul_product;
`endif

   always_comb begin
      op_mul   = 1'b0;
      op_div   = 1'b0;
      op_signd = 1'b0;
`ifdef MULDIV_MADD_EN
      op_acc   = ACC_SET;
`endif
      case (bus.op)
         MULDIV_OP_MULT:  begin op_mul = 1'b1; op_signd = 1'b1; end
         MULDIV_OP_MULTU: op_mul = 1'b1;
         MULDIV_OP_DIV:   begin op_div = 1'b1; op_signd = 1'b1; end
         MULDIV_OP_DIVU:  op_div = 1'b1;
`ifdef MULDIV_MADD_EN
         MULDIV_OP_MADD:  begin op_mul = 1'b1; op_signd = 1'b1; op_acc = ACC_ADD; end
         MULDIV_OP_MADDU: begin op_mul = 1'b1; op_acc = ACC_ADD; end
         MULDIV_OP_MSUB:  begin op_mul = 1'b1; op_signd = 1'b1; op_acc = ACC_SUB; end
         MULDIV_OP_MSUBU: begin op_mul = 1'b1; op_acc = ACC_SUB; end
`endif
         default: ;
      endcase
   end

   assign engine_ready = sel_div_reg ? div_ready : mul_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         hi_reg        <= '0;
         lo_reg        <= '0;
         mul_a_reg     <= '0;
         mul_b_reg     <= '0;
         div_a_reg     <= '0;
         div_b_reg     <= '0;
         mul_signd_reg <= 1'b0;
         div_signd_reg <= 1'b0;
         mul_start_reg <= 1'b0;
         div_start_reg <= 1'b0;
         sel_div_reg   <= 1'b0;
`ifdef MULDIV_MADD_EN
         acc_mode_reg  <= ACC_SET;
`endif
      end else begin
         mul_start_reg <= 1'b0;
         div_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // Only the selected engine's operand registers are reloaded, so an
               // abandoned engine keeps seeing stable inputs.
               if (bus.req && !bus.flush) begin
                  if (op_mul) begin
                     mul_a_reg     <= bus.a;
                     mul_b_reg     <= bus.b;
                     mul_signd_reg <= op_signd;
                     mul_start_reg <= 1'b1;
                     sel_div_reg   <= 1'b0;
`ifdef MULDIV_MADD_EN
                     acc_mode_reg  <= op_acc;
`endif
                     state_reg     <= ST_ISSUE;
                  end else if (op_div) begin
                     div_a_reg     <= bus.a;
                     div_b_reg     <= bus.b;
                     div_signd_reg <= op_signd;
                     div_start_reg <= 1'b1;
                     sel_div_reg   <= 1'b1;
                     state_reg     <= ST_ISSUE;
                  end else if (bus.op == MULDIV_OP_MTHI) begin
                     hi_reg <= bus.a;
                  end else if (bus.op == MULDIV_OP_MTLO) begin
                     lo_reg <= bus.a;
                  end
               end
            end
            ST_ISSUE: state_reg <= bus.flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
               if (bus.flush) begin
                  state_reg <= ST_IDLE;
               end else if (engine_ready) begin
                  state_reg <= ST_IDLE;
                  if (sel_div_reg) begin
                     lo_reg <= div_quot;
                     hi_reg <= div_rem;
                  end else begin
                     {hi_reg, lo_reg} <= mul_result;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy  = (state_reg != ST_IDLE);
   assign bus.hi    = hi_reg;
   assign bus.lo    = lo_reg;
   assign mul_start = mul_start_reg;
   assign mul_signd = mul_signd_reg;
   assign mul_a     = mul_a_reg;
   assign mul_b     = mul_b_reg;
   assign div_start = div_start_reg;
   assign div_signd = div_signd_reg;
   assign div_a     = div_a_reg;
   assign div_b     = div_b_reg;

endmodule
